result_readout: RTL and testbench
=================================

Name: result_readout

Overview:
- Downstream stage of the write-back path.
- Once the ALU signals completion and write-back has filled the result SRAM, this block reads NUM_WORDS 32-bit result words back out through a second SRAM port.
- It serialises each word into 8-bit bytes, most significant byte first, on a valid/ready output stream toward the chip output pads.
- It owns the SRAM control lines while busy and releases them when idle.

Parameters:
- NUM_WORDS, 16, number of 32-bit words read per run (1..256).
- BASE_ADDR, 0, first SRAM address read; BASE_ADDR+NUM_WORDS-1 must be ≤ 255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse (driven from ALU_done) that begins a readout run.
- ry  input  1  SRAM ready; read_data is valid in a cycle where ry=1 during RD_WAIT.
- read_data  input  32  SRAM read data.
- cs_n  output  1  SRAM chip select, active low.
- we_n  output  1  SRAM write enable, active low; this block only reads, so it is held 1.
- address  output  8  SRAM read address.
- dout  output  8  output byte.
- dout_valid  output  1  dout holds a valid byte.
- dout_ready  input  1  consumer accepts the byte when dout_valid & dout_ready.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last byte of the run is accepted.

Behaviour:
- Reset values (asynchronous, applied immediately): state=IDLE, cs_n=1, we_n=1, address=BASE_ADDR, dout=0, dout_valid=0, busy=0, done=0, word counter=0, byte counter=0.
- IDLE:
  - cs_n=1.
  - start=1 → RD_REQ, busy=1, address=BASE_ADDR, word counter=0.
- RD_REQ (1 cycle): cs_n=0, we_n=1, address stable → RD_WAIT.
- RD_WAIT:
  - cs_n=0.
  - ry=0: stay.
  - ry=1: capture read_data into a 32-bit shift register → SEND, byte counter=0, cs_n=1 from the next cycle.
- SEND:
  - dout = shift_reg[31:24], dout_valid=1.
  - On dout_valid & dout_ready: shift left 8, increment byte counter.
  - dout and dout_valid must not change while dout_valid=1 and dout_ready=0.
  - After the 4th accepted byte:
    - if word counter = NUM_WORDS-1 → FINISH;
    - else increment address and word counter → RD_REQ.
- Back-to-back acceptance gives 1 byte/clk.
- dout_valid drops to 0 in the cycle after the 4th byte is accepted (no bubble-free word chaining required).
- FINISH (1 cycle): done=1, busy=0 next cycle, address returns to BASE_ADDR → IDLE.
- Per-word latency with ry already high and dout_ready tied 1: RD_REQ 1 + RD_WAIT 1 + SEND 4 = 6 cycles.
- The first byte appears 3 cycles after the start pulse.
- start while busy (any state other than IDLE): ignored, no restart, no error.
- start in the same cycle as FINISH: ignored; a new start must come in IDLE.
- Address arithmetic is 8-bit. The parameter constraint guarantees no wrap; wrap behaviour is not exercised.
- dout_ready while dout_valid=0: no effect.
- Reset asserted mid-run (any state) forces all reset values at once:
  - an in-flight byte is dropped;
  - done is not pulsed;
  - the run is not resumed after reset release.
- we_n is constant 1 in every state. The write-back block's we_n and this block's cs_n are muxed at top level by busy.

Test Plan:
- Reset then idle: rst=1 mid-cycle → cs_n=1, dout_valid=0, busy=0, address=0 immediately; no activity for 20 cycles with start=0.
- Single word: NUM_WORDS=1, SRAM[0]=0xDEADBEEF, ry=1, dout_ready=1, start pulse → bytes DE, AD, BE, EF on 4 consecutive cycles starting 3 cycles after start; done pulses once; busy low afterward.
- Full run with ry stalls: NUM_WORDS=16, SRAM[i]=i*0x01010101, ry low for 3 cycles on each read → 64 bytes in address order, values 00×4, 01×4 … 0F×4; address sequence 0..15; done after byte 64.
- Backpressure: dout_ready toggled 1,0,0,1 pattern on word 0x11223344 → dout holds each byte stable while ready=0; exactly 4 handshakes, order 11, 22, 33, 44.
- Spurious start: start pulsed during SEND of word 2 → no restart; total byte count is still 4×NUM_WORDS; a single done pulse.
- Reset mid-run: assert rst during SEND of word 5 for 1 cycle → outputs at reset values, no done pulse; a new start re-reads from BASE_ADDR, first byte = SRAM[0][31:24].

Source files
------------

// File: rtl/result_readout_if.sv
// result_readout_if: SRAM read port, start/status and byte stream of the readout block.
interface result_readout_if;
    logic        start;
    logic        ry;
    logic [31:0] read_data;
    logic        cs_n;
    logic        we_n;
    logic [7:0]  address;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    modport master (
        input  start, ry, read_data, dout_ready,
        output cs_n, we_n, address, dout, dout_valid, busy, done
    );
    modport slave (
        output start, ry, read_data, dout_ready,
        input  cs_n, we_n, address, dout, dout_valid, busy, done
    );
endinterface

// File: rtl/result_readout.sv
// result_readout: reads NUM_WORDS result words from SRAM and streams them out MSB byte first.
module result_readout #(
    parameter int         NUM_WORDS = 16,
    parameter logic [7:0] BASE_ADDR = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    result_readout_if.master io_bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;
    logic [2:0]  r_state;
    logic [7:0]  r_addr;
    logic [7:0]  r_word;
    logic [1:0]  r_byte;
    logic [31:0] r_shift;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic        w_fire;
    logic        w_last_byte;
    logic        w_last_word;
    assign w_fire      = r_valid & io_bus.dout_ready;
    assign w_last_byte = r_byte == 2'd3;
    assign w_last_word = r_word == 8'(NUM_WORDS - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= BASE_ADDR;
            r_word  <= 8'd0;
            r_byte  <= 2'd0;
            r_shift <= 32'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (io_bus.start) begin
                    r_state <= S_RD_REQ;
                    r_busy  <= 1'b1;
                    r_addr  <= BASE_ADDR;
                    r_word  <= 8'd0;
                end
                S_RD_REQ: r_state <= S_RD_WAIT;
                S_RD_WAIT: if (io_bus.ry) begin
                    r_shift <= io_bus.read_data;
                    r_byte  <= 2'd0;
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: if (w_fire) begin
                    r_shift <= {r_shift[23:0], 8'h00};
                    r_byte  <= r_byte + 2'd1;
                    if (w_last_byte) begin
                        r_valid <= 1'b0;
                        if (w_last_word) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 8'd1;
                            r_word  <= r_word + 8'd1;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_addr  <= BASE_ADDR;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    // chip select is asserted only while a read is outstanding
    assign io_bus.cs_n       = !(r_state == S_RD_REQ || r_state == S_RD_WAIT);
    assign io_bus.we_n       = 1'b1;
    assign io_bus.address    = r_addr;
    assign io_bus.dout       = r_shift[31:24];
    assign io_bus.dout_valid = r_valid;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
endmodule

// File: tb/tb_result_readout.sv
// tb_result_readout: directed runs with an SRAM model, stall/backpressure control and a byte scoreboard.
module tb_result_readout;
    localparam int NW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    result_readout_if bus ();
    result_readout #(.NUM_WORDS(NW), .BASE_ADDR(8'd0)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    logic [31:0] mem [0:255];
    logic [7:0]  q [$];
    int total = 0;
    int bad = 0;
    int stall = 0;
    int cnt = 0;
    int rdy_mode = 0;
    int hs_count = 0;
    int done_count = 0;
    int exp_addr = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    assign bus.read_data = mem[bus.address];
    assign bus.ry = cnt > stall;
    always @(posedge clk) cnt <= bus.cs_n ? 0 : cnt + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    initial begin
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        bus.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_ready = rdy_mode == 0 ? 1'b1 : pat[3 - (idx % 4)];
            idx++;
        end
    end
    always @(negedge clk) begin
        if (rst) pend = 1'b0;
        else begin
            if (pend) chk("hold", {23'd0, bus.dout_valid, bus.dout}, {23'd0, 1'b1, pend_byte});
            if (!bus.cs_n && bus.ry) begin
                chk("addr", {24'd0, bus.address}, exp_addr);
                exp_addr++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                hs_count++;
                chk("q_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("byte", {24'd0, bus.dout}, {24'd0, q.pop_front()});
            end
            pend = bus.dout_valid && !bus.dout_ready;
            pend_byte = bus.dout;
            if (bus.done) done_count++;
        end
    end
    task automatic push_run();
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++) q.push_back(mem[w][31 - 8*b -: 8]);
    endtask
    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic begin_run();
        exp_addr = 0;
        push_run();
        pulse_start();
    endtask
    task automatic wait_done(input int snap);
        int k;
        k = 0;
        while (done_count == snap && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_timeout", k < 3000, 1);
    endtask
    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_count < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("hs_timeout", k < 3000, 1);
    endtask
    task automatic check_reset_vals(input string tag);
        chk({tag, "_cs_n"}, bus.cs_n, 1);
        chk({tag, "_we_n"}, bus.we_n, 1);
        chk({tag, "_valid"}, bus.dout_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_addr"}, bus.address, 0);
        chk({tag, "_dout"}, bus.dout, 0);
    endtask
    initial begin
        int hs0, d0;
        logic [31:0] w0;
        bus.start = 1'b0;
        mem[0] = 32'hDEADBEEF;
        for (int i = 1; i < 256; i++) mem[i] = i * 32'h01010101;
        #3 rst = 1'b1;
        #1 check_reset_vals("rst0");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_cs_n", bus.cs_n, 1);
        chk("idle_hs", hs_count, 0);
        chk("idle_done", done_count, 0);
        // run 1: no stalls, first byte three cycles after start
        hs0 = hs_count;
        d0 = done_count;
        begin_run();
        chk("busy_after_start", bus.busy, 1);
        @(posedge clk);
        #1 chk("early_valid", bus.dout_valid, 0);
        @(posedge clk);
        #1;
        chk("first_valid", bus.dout_valid, 1);
        chk("first_byte", bus.dout, 8'hDE);
        w0 = 32'hADBEEF00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("consec_valid", bus.dout_valid, 1);
            chk("consec_byte", bus.dout, w0[31:24]);
            w0 = w0 << 8;
        end
        @(posedge clk);
        #1 chk("gap_after_word", bus.dout_valid, 0);
        wait_done(d0);
        chk("run1_bytes", hs_count - hs0, 4 * NW);
        @(posedge clk);
        #1;
        chk("run1_busy_low", bus.busy, 0);
        chk("run1_done_once", done_count - d0, 1);
        // run 2: read stalls plus a spurious start mid-run
        stall = 3;
        mem[0] = 32'h00000000;
        hs0 = hs_count;
        d0 = done_count;
        begin_run();
        wait_hs(hs0 + 9);
        pulse_start();
        wait_done(d0);
        repeat (10) @(posedge clk);
        #1;
        chk("run2_bytes", hs_count - hs0, 4 * NW);
        chk("run2_done_once", done_count - d0, 1);
        chk("run2_busy_low", bus.busy, 0);
        chk("run2_q_empty", q.size(), 0);
        // run 3: backpressure pattern
        stall = 0;
        rdy_mode = 1;
        mem[0] = 32'h11223344;
        hs0 = hs_count;
        d0 = done_count;
        begin_run();
        wait_done(d0);
        repeat (3) @(posedge clk);
        #1;
        chk("run3_bytes", hs_count - hs0, 4 * NW);
        chk("run3_done_once", done_count - d0, 1);
        chk("run3_q_empty", q.size(), 0);
        // run 4: reset during SEND of word 5
        rdy_mode = 0;
        hs0 = hs_count;
        d0 = done_count;
        begin_run();
        wait_hs(hs0 + 21);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_vals("rst_mid");
        q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        hs0 = hs_count;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_count, d0);
        chk("no_resume_hs", hs_count, hs0);
        chk("no_resume_busy", bus.busy, 0);
        // run 5: restart re-reads from BASE_ADDR
        hs0 = hs_count;
        begin_run();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("restart_valid", bus.dout_valid, 1);
        chk("restart_first", bus.dout, 8'h11);
        wait_done(d0);
        @(posedge clk);
        #1;
        chk("run5_bytes", hs_count - hs0, 4 * NW);
        chk("run5_done_once", done_count - d0, 1);
        chk("run5_busy_low", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
